// File: rtl/exc_vector_seq_pkg.sv
// Shared definitions for the exception vector sequencer: mux select codes,
// cause codes, FSM state encodings and the cause-to-vector mapping.
package exc_vector_seq_pkg;

    localparam logic [2:0] SEL_PC   = 3'd0;
    localparam logic [2:0] SEL_V253 = 3'd2;
    localparam logic [2:0] SEL_V254 = 3'd3;
    localparam logic [2:0] SEL_V255 = 3'd4;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_OPC  = 2'd1,
        CAUSE_OVF  = 2'd2,
        CAUSE_DIV  = 2'd3
    } cause_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VEC  = 2'd1,
        ST_WAIT = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    function automatic logic [2:0] vector_sel(input cause_t c);
        case (c)
            CAUSE_OPC: vector_sel = SEL_V253;
            CAUSE_OVF: vector_sel = SEL_V254;
            CAUSE_DIV: vector_sel = SEL_V255;
            default:   vector_sel = SEL_PC;
        endcase
    endfunction

endpackage

// File: rtl/exc_vector_seq.sv
// Multicycle exception sequencer: saves EPC = PC-4, fetches the handler byte
// from the cause's vector address and loads it, zero-extended, into PC.
module exc_vector_seq
    import exc_vector_seq_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic [31:0] pc_value,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [2:0]  mem_addr_sel,
    output logic        mem_wr,
    output logic        epc_we,
    output logic [31:0] epc_data,
    output logic        pc_we,
    output logic [31:0] pc_data,
    output logic [1:0]  cause,
    output logic        done,
    output logic [1:0]  state_dbg
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t            state, state_nx;
    cause_t            cause_q, cause_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;

    // Only the handler byte is consumed; the upper read bits are don't-care.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^mem_rdata[31:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            cause_q <= cause_nx;
            cnt     <= cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cause_nx     = cause_q;
        cnt_nx       = cnt;
        busy         = 1'b0;
        mem_addr_sel = SEL_PC;
        mem_wr       = 1'b0;
        epc_we       = 1'b0;
        epc_data     = 32'd0;
        pc_we        = 1'b0;
        pc_data      = 32'd0;
        done         = 1'b0;

        case (state)
            ST_IDLE: begin
                // Fixed priority; lower-priority requests in the same cycle are dropped.
                if (exc_opcode) begin
                    cause_nx = CAUSE_OPC;
                    state_nx = ST_VEC;
                end else if (exc_overflow) begin
                    cause_nx = CAUSE_OVF;
                    state_nx = ST_VEC;
                end else if (exc_divzero) begin
                    cause_nx = CAUSE_DIV;
                    state_nx = ST_VEC;
                end
            end
            ST_VEC: begin
                busy         = 1'b1;
                mem_addr_sel = vector_sel(cause_q);
                epc_we       = 1'b1;
                epc_data     = pc_value - 32'd4;
                cnt_nx       = CNT_INIT;
                state_nx     = ST_WAIT;
            end
            ST_WAIT: begin
                busy         = 1'b1;
                mem_addr_sel = vector_sel(cause_q);
                if (cnt == '0) begin
                    state_nx = ST_LOAD;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            ST_LOAD: begin
                busy         = 1'b1;
                mem_addr_sel = vector_sel(cause_q);
                pc_we        = 1'b1;
                pc_data      = {24'd0, mem_rdata[7:0]};
                done         = 1'b1;
                cause_nx     = CAUSE_NONE;
                state_nx     = ST_IDLE;
            end
            default: begin
                cause_nx = CAUSE_NONE;
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign cause     = cause_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_exc_vector_seq.sv
// Randomized and directed bench for exc_vector_seq against a cycle-position
// reference model, with a latency-accurate vector memory beside the DUT.
module tb_exc_vector_seq;

    localparam int MEM_LAT = 2;
    localparam int SEQ_LEN = MEM_LAT + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_opcode, exc_overflow, exc_divzero;
    logic [31:0] pc_value, mem_rdata;
    logic        busy, mem_wr, epc_we, pc_we, done;
    logic [2:0]  mem_addr_sel;
    logic [31:0] epc_data, pc_data;
    logic [1:0]  cause, state_dbg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exc_vector_seq #(.MEM_LAT(MEM_LAT), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_divzero(exc_divzero),
        .pc_value(pc_value), .mem_rdata(mem_rdata),
        .busy(busy), .mem_addr_sel(mem_addr_sel), .mem_wr(mem_wr),
        .epc_we(epc_we), .epc_data(epc_data), .pc_we(pc_we), .pc_data(pc_data),
        .cause(cause), .done(done), .state_dbg(state_dbg)
    );

    // Vector memory: bytes at 253/254/255, valid only MEM_LAT cycles after the
    // address settles; otherwise the bus carries random junk.
    logic [7:0]  handler [3];
    logic [2:0]  last_sel = 3'd0;
    int          stable_cnt = 0;
    logic [31:0] junk = 32'd0;

    always @(posedge clk) begin
        junk <= $urandom;
        if (mem_addr_sel == last_sel) begin
            if (stable_cnt < 100) stable_cnt <= stable_cnt + 1;
        end else begin
            stable_cnt <= 0;
        end
        last_sel <= mem_addr_sel;
    end

    always_comb begin
        mem_rdata = junk;
        if (stable_cnt >= MEM_LAT - 1 && mem_addr_sel >= 3'd2 && mem_addr_sel <= 3'd4)
            mem_rdata = {junk[31:8], handler[mem_addr_sel - 3'd2]};
    end

    // Reference model: pos counts cycles into a sequence (0 = idle).
    int          pos = 0;
    logic [1:0]  m_cause = 2'd0;
    logic [31:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] vec_of(input logic [1:0] c);
        return 3'd1 + {1'b0, c};
    endfunction

    task automatic check_outputs();
        logic [31:0] exp_pcd;
        exp_pcd = (pos == SEQ_LEN) ? {24'd0, handler[m_cause - 1]} : 32'd0;
        check_val("busy",     busy,         (pos != 0));
        check_val("sel",      mem_addr_sel, (pos != 0) ? vec_of(m_cause) : 3'd0);
        check_val("mem_wr",   mem_wr,       1'b0);
        check_val("epc_we",   epc_we,       (pos == 1));
        check_val("epc_data", epc_data,     (pos == 1) ? pc_value - 32'd4 : 32'd0);
        check_val("pc_we",    pc_we,        (pos == SEQ_LEN));
        check_val("done",     done,         (pos == SEQ_LEN));
        check_val("pc_data",  pc_data,      exp_pcd);
        check_val("cause",    cause,        (pos != 0) ? m_cause : 2'd0);
        if (pc_we === 1'b1) begin
            check_val("sb_load_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) check_val("sb_pc_data", pc_data, exp_q.pop_front());
        end
    endtask

    // Called at a falling edge: drive, take one rising edge, update model, check.
    task automatic step(input logic opc, input logic ovf, input logic div,
                        input logic [31:0] pc, input logic rst);
        exc_opcode   = opc;
        exc_overflow = ovf;
        exc_divzero  = div;
        pc_value     = pc;
        reset        = rst;
        if (rst) begin
            #1;
            check_val("async_rst_busy", busy, 1'b0);
            check_val("async_rst_sel",  mem_addr_sel, 3'd0);
            check_val("async_rst_pcwe", pc_we, 1'b0);
        end
        @(posedge clk);
        if (rst) begin
            pos = 0;
            m_cause = 2'd0;
            exp_q.delete();
        end else if (pos == 0) begin
            if (opc | ovf | div) begin
                m_cause = opc ? 2'd1 : (ovf ? 2'd2 : 2'd3);
                pos = 1;
                exp_q.push_back({24'd0, handler[m_cause - 1]});
            end
        end else if (pos == SEQ_LEN) begin
            pos = 0;
        end else begin
            pos++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic [31:0] pc);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, pc, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        exc_opcode = 1'b0; exc_overflow = 1'b0; exc_divzero = 1'b0;
        pc_value = 32'd0;
        handler[0] = 8'h5E; handler[1] = 8'hA7; handler[2] = 8'h33;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // Quiet after reset.
        idle(10, 32'h0000_1000);

        // Overflow pulse at PC 0x40, handler byte 0xA7.
        step(1'b0, 1'b1, 1'b0, 32'h40, 1'b0);
        idle(SEQ_LEN + 2, 32'h40);

        // Opcode and divzero together: only opcode serviced.
        step(1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
        idle(SEQ_LEN + 6, 32'h200);

        // PC wrap on EPC, vector 255.
        step(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        idle(SEQ_LEN + 2, 32'd0);

        // Reset during WAIT aborts the sequence.
        step(1'b0, 1'b1, 1'b0, 32'h100, 1'b0);
        idle(1, 32'h100);
        step(1'b0, 1'b0, 1'b0, 32'h100, 1'b1);
        idle(SEQ_LEN + 2, 32'h100);

        // Overflow re-asserted while waiting is ignored.
        step(1'b0, 1'b1, 1'b0, 32'h80, 1'b0);
        idle(1, 32'h80);
        step(1'b0, 1'b1, 1'b0, 32'h80, 1'b0);
        idle(SEQ_LEN + 2, 32'h80);

        // Level held high: back-to-back sequences.
        for (int i = 0; i < 2 * (SEQ_LEN + 1); i++) step(1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
        idle(SEQ_LEN + 2, 32'h44);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (pos == 0) begin
                handler[0] = 8'($urandom);
                handler[1] = 8'($urandom);
                handler[2] = 8'($urandom);
            end
            step(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), $urandom, ($urandom_range(0, 49) == 0));
        end
        idle(SEQ_LEN + 2, 32'h0);
        check_val("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
